// File: rtl/bf_program_sequencer.sv
// Loads filtered Brainfuck commands from a UART byte stream into the
// instruction RAM, checks bracket balance and capacity, then runs the core.
// Ports: sysClk/extReset (async active-low); loadReq/runReq request pulses;
// rxValid/rxData received bytes; procDone core done flag; memWe/memAddr/
// memData RAM write port; procReset active-low core reset; loading/running/
// error status; progLen number of stored commands.
// Optional macro BF_LOAD_STRICT_EN: non-command bytes during load are errors.
`timescale 1ns/1ps
module bf_program_sequencer #(
  parameter int ADDR_WIDTH = 4,
  parameter logic [7:0] TERMINATOR = 8'h21,
  parameter int RESET_HOLD = 2
) (
  input  logic                  sysClk,
  input  logic                  extReset,
  input  logic                  loadReq,
  input  logic                  runReq,
  input  logic                  rxValid,
  input  logic [7:0]            rxData,
  input  logic                  procDone,
  output logic                  memWe,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic [7:0]            memData,
  output logic                  procReset,
  output logic                  loading,
  output logic                  running,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   progLen
);

  localparam int CAPI = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CAP = CAPI[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] ONE = (ADDR_WIDTH+1)'(1);
  localparam int HW = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_HOLD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_HOLD,
    S_RUN,
    S_HALT,
    S_ERR
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH:0]   depth;
  logic [HW-1:0]         hold_cnt;

  logic is_cmd;
  logic is_open;
  logic is_close;
  logic is_term;
  logic full;

  always_comb begin
    is_cmd   = rxData inside {8'h2B, 8'h2D, 8'h3C, 8'h3E,
                              8'h5B, 8'h5D, 8'h2E, 8'h2C};
    is_open  = (rxData == 8'h5B);
    is_close = (rxData == 8'h5D);
    is_term  = (rxData == TERMINATOR);
    full     = (progLen == CAP);
  end

  always_ff @(posedge sysClk or negedge extReset) begin
    if (!extReset) begin
      state     <= S_IDLE;
      memWe     <= 1'b0;
      memAddr   <= '0;
      memData   <= '0;
      procReset <= 1'b0;
      loading   <= 1'b0;
      running   <= 1'b0;
      error     <= 1'b0;
      progLen   <= '0;
      depth     <= '0;
      hold_cnt  <= '0;
    end else begin
      memWe <= 1'b0;
      // A load request restarts loading from every state except HOLD,
      // and wins over any other event in the same cycle.
      if (loadReq && state != S_HOLD) begin
        state     <= S_LOAD;
        loading   <= 1'b1;
        running   <= 1'b0;
        procReset <= 1'b0;
        error     <= 1'b0;
        progLen   <= '0;
        depth     <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (runReq) begin
              state    <= S_HOLD;
              hold_cnt <= '0;
            end
          end
          S_LOAD: begin
            if (rxValid) begin
              if (is_cmd) begin
                if (full || (is_close && depth == '0)) begin
                  state   <= S_ERR;
                  loading <= 1'b0;
                  error   <= 1'b1;
                end else begin
                  memWe   <= 1'b1;
                  memAddr <= progLen[ADDR_WIDTH-1:0];
                  memData <= rxData;
                  progLen <= progLen + ONE;
                  if (is_open) depth <= depth + ONE;
                  else if (is_close) depth <= depth - ONE;
                end
              end else if (is_term) begin
                if (depth != '0) begin
                  state   <= S_ERR;
                  loading <= 1'b0;
                  error   <= 1'b1;
                end else begin
                  // Zero marks end of program when there is room for it.
                  if (!full) begin
                    memWe   <= 1'b1;
                    memAddr <= progLen[ADDR_WIDTH-1:0];
                    memData <= 8'h00;
                  end
                  state    <= S_HOLD;
                  loading  <= 1'b0;
                  hold_cnt <= '0;
                end
              end
`ifdef BF_LOAD_STRICT_EN
              else begin
                state   <= S_ERR;
                loading <= 1'b0;
                error   <= 1'b1;
              end
`else
              else begin
                state <= S_LOAD;
              end
`endif
            end
          end
          S_HOLD: begin
            if (hold_cnt == HOLD_LAST) begin
              state     <= S_RUN;
              procReset <= 1'b1;
              running   <= 1'b1;
            end else begin
              hold_cnt <= hold_cnt + HW'(1);
            end
          end
          S_RUN: begin
            if (procDone) begin
              state   <= S_HALT;
              running <= 1'b0;
            end
          end
          S_HALT: begin
            if (runReq) begin
              state     <= S_HOLD;
              procReset <= 1'b0;
              hold_cnt  <= '0;
            end
          end
          S_ERR: begin
            state <= S_ERR;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bf_program_sequencer.sv
// Self-checking bench for bf_program_sequencer: directed scenarios plus
// random programs compared against a byte-stream reference model.
`timescale 1ns/1ps
module tb_bf_program_sequencer;

  localparam int AW = 4;
  localparam int CAP = 16;
  localparam int RH = 2;
`ifdef BF_LOAD_STRICT_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif

  logic          sysClk = 1'b0;
  logic          extReset;
  logic          loadReq;
  logic          runReq;
  logic          rxValid;
  logic [7:0]    rxData;
  logic          procDone;
  logic          memWe;
  logic [AW-1:0] memAddr;
  logic [7:0]    memData;
  logic          procReset;
  logic          loading;
  logic          running;
  logic          error;
  logic [AW:0]   progLen;

  int checks = 0;
  int errors = 0;

  logic [7:0] prog[$];
  int         got_a[$];
  int         got_d[$];
  int         exp_a[$];
  int         exp_d[$];
  int         exp_len;
  int         exp_out;

  bf_program_sequencer #(
    .ADDR_WIDTH(AW),
    .TERMINATOR(8'h21),
    .RESET_HOLD(RH)
  ) dut (
    .sysClk(sysClk),
    .extReset(extReset),
    .loadReq(loadReq),
    .runReq(runReq),
    .rxValid(rxValid),
    .rxData(rxData),
    .procDone(procDone),
    .memWe(memWe),
    .memAddr(memAddr),
    .memData(memData),
    .procReset(procReset),
    .loading(loading),
    .running(running),
    .error(error),
    .progLen(progLen)
  );

  always #5 sysClk = ~sysClk;

  always @(negedge sysClk) begin
    if (memWe === 1'b1) begin
      got_a.push_back(int'(memAddr));
      got_d.push_back(int'(memData));
    end
  end

  task automatic tick();
    @(posedge sysClk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_prog(input string s);
    prog.delete();
    for (int i = 0; i < s.len(); i++) prog.push_back(s[i]);
  endtask

  function automatic bit is_cmd_m(input logic [7:0] b);
    return b == "+" || b == "-" || b == "<" || b == ">" ||
           b == "[" || b == "]" || b == "." || b == ",";
  endfunction

  // Outcome: 0 still loading, 1 loaded and running, 2 load error.
  task automatic model();
    int cnt;
    int dep;
    logic [7:0] b;
    cnt = 0;
    dep = 0;
    exp_a.delete();
    exp_d.delete();
    exp_out = 0;
    for (int i = 0; i < prog.size(); i++) begin
      b = prog[i];
      if (is_cmd_m(b)) begin
        if (cnt == CAP || (b == "]" && dep == 0)) begin
          exp_out = 2;
          break;
        end
        exp_a.push_back(cnt);
        exp_d.push_back(int'(b));
        cnt++;
        if (b == "[") dep++;
        if (b == "]") dep--;
      end else if (b == "!") begin
        if (dep != 0) begin
          exp_out = 2;
          break;
        end
        if (cnt < CAP) begin
          exp_a.push_back(cnt);
          exp_d.push_back(0);
        end
        exp_out = 1;
        break;
      end else if (STRICT) begin
        exp_out = 2;
        break;
      end
    end
    exp_len = cnt;
  endtask

  task automatic compare_writes(input string tag);
    int n;
    chk({tag, "_nwr"}, got_a.size(), exp_a.size());
    n = (got_a.size() < exp_a.size()) ? got_a.size() : exp_a.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_addr"}, got_a[i], exp_a[i]);
      chk({tag, "_data"}, got_d[i], exp_d[i]);
    end
  endtask

  task automatic start_load();
    loadReq = 1'b1;
    tick();
    loadReq = 1'b0;
    got_a.delete();
    got_d.delete();
    chk("ld_loading", loading, 1);
    chk("ld_error", error, 0);
    chk("ld_len", progLen, 0);
    chk("ld_prst", procReset, 0);
  endtask

  task automatic run_prog(input string tag, input bit gaps);
    start_load();
    for (int i = 0; i < prog.size(); i++) begin
      rxValid = 1'b1;
      rxData = prog[i];
      tick();
      rxValid = 1'b0;
      rxData = 8'h00;
      if (gaps && $urandom_range(0, 3) == 0) tick();
    end
    repeat (RH + 2) tick();
    model();
    compare_writes(tag);
    chk({tag, "_len"}, progLen, exp_len);
    chk({tag, "_err"}, error, exp_out == 2);
    chk({tag, "_loading"}, loading, exp_out == 0);
    chk({tag, "_running"}, running, exp_out == 1);
    chk({tag, "_prst"}, procReset, exp_out == 1);
  endtask

  initial begin
    logic [7:0] cmds[8];
    logic [7:0] junk[3];
    int len;
    int r;
    cmds = '{8'h2B, 8'h2D, 8'h3C, 8'h3E, 8'h5B, 8'h5D, 8'h2E, 8'h2C};
    junk = '{8'h61, 8'h20, 8'h0A};

    extReset = 1'b0;
    loadReq = 1'b0;
    runReq = 1'b0;
    rxValid = 1'b0;
    rxData = 8'h00;
    procDone = 1'b0;
    repeat (2) tick();
    chk("rst_we", memWe, 0);
    chk("rst_addr", memAddr, 0);
    chk("rst_data", memData, 0);
    chk("rst_prst", procReset, 0);
    chk("rst_loading", loading, 0);
    chk("rst_running", running, 0);
    chk("rst_error", error, 0);
    chk("rst_len", progLen, 0);
    extReset = 1'b1;
    tick();
    chk("idle_loading", loading, 0);

    // Basic program with timing of the processor reset release.
    set_prog("+[.+]!");
    start_load();
    for (int i = 0; i < prog.size(); i++) begin
      rxValid = 1'b1;
      rxData = prog[i];
      tick();
    end
    rxValid = 1'b0;
    chk("b_hold1_prst", procReset, 0);
    chk("b_hold1_loading", loading, 0);
    tick();
    chk("b_hold2_prst", procReset, 0);
    chk("b_hold2_running", running, 0);
    tick();
    chk("b_run_prst", procReset, 1);
    chk("b_run_running", running, 1);
    chk("b_len", progLen, 5);
    model();
    compare_writes("b");
    chk("b_model_len", exp_len, 5);

    // Done -> HALT, then re-run.
    procDone = 1'b1;
    tick();
    procDone = 1'b0;
    chk("halt_running", running, 0);
    chk("halt_prst", procReset, 1);
    tick();
    chk("halt_stay", procReset, 1);
    runReq = 1'b1;
    tick();
    runReq = 1'b0;
    chk("rerun1_prst", procReset, 0);
    tick();
    chk("rerun2_prst", procReset, 0);
    tick();
    chk("rerun_prst", procReset, 1);
    chk("rerun_running", running, 1);

    // Unbalanced close bracket, then recovery.
    set_prog("]");
    run_prog("close", 1'b0);
    set_prog("+!");
    run_prog("recover", 1'b0);

    // Capacity boundary.
    set_prog("+++++++++++++++++");
    run_prog("ovf", 1'b0);
    set_prog("++++++++++++++++!");
    run_prog("full_term", 1'b0);

    // Comments and whitespace.
    set_prog("a+ b!");
    run_prog("comment", 1'b0);

    // Depth left open at terminator.
    set_prog("[[+]!");
    run_prog("open", 1'b0);

    // Random programs.
    for (int t = 0; t < 25; t++) begin
      prog.delete();
      len = $urandom_range(1, 20);
      for (int i = 0; i < len; i++) begin
        r = $urandom_range(0, 9);
        if (r < 6) prog.push_back(cmds[$urandom_range(0, 7)]);
        else if (r < 8) prog.push_back(r == 6 ? 8'h5B : 8'h5D);
        else if (r == 8 && !STRICT) prog.push_back(junk[$urandom_range(0, 2)]);
        else prog.push_back(8'h2B);
      end
      if ($urandom_range(0, 3) != 0) prog.push_back(8'h21);
      run_prog("rand", 1'b1);
    end

    // Asynchronous reset in the middle of loading.
    set_prog("+++");
    start_load();
    for (int i = 0; i < 3; i++) begin
      rxValid = 1'b1;
      rxData = prog[i];
      tick();
    end
    rxValid = 1'b0;
    chk("mid_we_before", memWe, 1);
    extReset = 1'b0;
    #1;
    chk("mid_we", memWe, 0);
    chk("mid_addr", memAddr, 0);
    chk("mid_len", progLen, 0);
    chk("mid_loading", loading, 0);
    chk("mid_prst", procReset, 0);
    tick();
    extReset = 1'b1;
    tick();
    chk("mid_idle_loading", loading, 0);
    chk("mid_idle_running", running, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
